// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction FIFO between fetch and decode; define IRQ_BYPASS_EN for same-cycle empty-queue bypass.
module ir_queue #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ir_ld,
    input  logic [WIDTH-1:0] ins,
    input  logic             ir_next,
    input  logic             flush,
    output logic [WIDTH-1:0] instruction,
    output logic             ir_valid,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             ovf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             w_empty, w_full, w_byp, w_push, w_pop;
`ifdef IRQ_BYPASS_EN
    assign w_byp = w_empty && ir_ld && !flush;
`else
    assign w_byp = 1'b0;
`endif
    always_comb begin
        w_empty     = r_count == '0;
        w_full      = r_count == CW'(DEPTH);
        // A bypassed word consumed in the same cycle is never stored
        w_push      = ir_ld && (!w_full || ir_next) && !(w_byp && ir_next);
        w_pop       = ir_next && !w_empty;
        ir_valid    = !w_empty || w_byp;
        instruction = !w_empty ? r_mem[r_rp] : (w_byp ? ins : '0);
        full        = w_full;
        count       = r_count;
        ovf         = r_ovf;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
            if (w_pop) r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (ir_ld && w_full && !ir_next) r_ovf <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) r_mem[r_wp] <= ins;
    end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed checks of ir_queue with DEPTH=4 and a DEPTH=3 wrap instance.
module tb_ir_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        ir_ld, ir_next, flush;
    logic [11:0] ins;
    logic [11:0] instruction;
    logic        ir_valid, full, ovf;
    logic [2:0]  count;
    logic        ld3, next3;
    logic [11:0] ins3, instr3;
    logic        valid3, full3, ovf3;
    logic [1:0]  count3;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ir_queue #(.WIDTH(12), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ir_ld(ir_ld), .ins(ins), .ir_next(ir_next), .flush(flush),
        .instruction(instruction), .ir_valid(ir_valid), .full(full), .count(count), .ovf(ovf)
    );

    ir_queue #(.WIDTH(12), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .ir_ld(ld3), .ins(ins3), .ir_next(next3), .flush(1'b0),
        .instruction(instr3), .ir_valid(valid3), .full(full3), .count(count3), .ovf(ovf3)
    );

    task automatic cyc(input logic ld, input logic [11:0] d, input logic nx, input logic fl);
        ir_ld = ld; ins = d; ir_next = nx; flush = fl;
        @(posedge clk); #1;
        ir_ld = 1'b0; ir_next = 1'b0; flush = 1'b0; ins = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ir_ld = 0; ir_next = 0; flush = 0; ins = '0;
        ld3 = 0; next3 = 0; ins3 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ir_valid); end
        n_tests++; if (instruction !== 12'h000) begin n_fail++; $display("FAIL reset_instr got %h exp 000", instruction); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_tests++; if (count3 !== 2'd0) begin n_fail++; $display("FAIL reset_count3 got %0d exp 0", count3); end
    endtask

    task automatic test_fill_order;
        logic [11:0] exp_q [4] = '{12'hA02, 12'hA03, 12'hA04, 12'h000};
        for (int i = 1; i <= 4; i++) cyc(1'b1, 12'hA00 + 12'(i), 1'b0, 1'b0);
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count); end
        n_tests++; if (instruction !== 12'hA01) begin n_fail++; $display("FAIL fill_head got %h exp A01", instruction); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (instruction !== exp_q[i]) begin n_fail++; $display("FAIL pop_order[%0d] got %h exp %h", i, instruction, exp_q[i]); end
        end
        n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", ir_valid); end
    endtask

    task automatic test_overflow;
        logic [11:0] exp_q [3] = '{12'hA03, 12'hA04, 12'hCCC};
        for (int i = 1; i <= 4; i++) cyc(1'b1, 12'hA00 + 12'(i), 1'b0, 1'b0);
        cyc(1'b1, 12'hBBB, 1'b0, 1'b0);
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        n_tests++; if (instruction !== 12'hA01) begin n_fail++; $display("FAIL ovf_head got %h exp A01", instruction); end
        cyc(1'b1, 12'hCCC, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpp_count got %0d exp 4", count); end
        n_tests++; if (instruction !== 12'hA02) begin n_fail++; $display("FAIL fullpp_head got %h exp A02", instruction); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (instruction !== exp_q[i]) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, instruction, exp_q[i]); end
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL ovf_drain got %0d exp 0", count); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) cyc(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", count); end
        cyc(1'b1, 12'hDDD, 1'b1, 1'b1);
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", ir_valid); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %b exp 0", ovf); end
        n_tests++; if (instruction !== 12'h000) begin n_fail++; $display("FAIL flush_instr got %h exp 000", instruction); end
        cyc(1'b1, 12'h321, 1'b0, 1'b0);
        n_tests++; if (instruction !== 12'h321) begin n_fail++; $display("FAIL postflush_head got %h exp 321", instruction); end
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_empty_push_pop;
        ir_ld = 1'b1; ins = 12'h5A5; ir_next = 1'b1; flush = 1'b0;
        #1;
`ifdef IRQ_BYPASS_EN
        n_tests++; if (instruction !== 12'h5A5) begin n_fail++; $display("FAIL byp_instr got %h exp 5A5", instruction); end
        n_tests++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got %b exp 1", ir_valid); end
        @(posedge clk); #1;
        ir_ld = 1'b0; ir_next = 1'b0; ins = '0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count got %0d exp 0", count); end
`else
        n_tests++; if (instruction !== 12'h000) begin n_fail++; $display("FAIL nobyp_instr got %h exp 000", instruction); end
        n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_valid got %b exp 0", ir_valid); end
        @(posedge clk); #1;
        ir_ld = 1'b0; ir_next = 1'b0; ins = '0;
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL nobyp_count got %0d exp 1", count); end
        n_tests++; if (instruction !== 12'h5A5) begin n_fail++; $display("FAIL nobyp_head got %h exp 5A5", instruction); end
`endif
    endtask

    task automatic test_wrap;
        ld3 = 1'b1; ins3 = 12'hE00;
        @(posedge clk); #1;
        for (int i = 1; i <= 7; i++) begin
            ld3 = 1'b1; next3 = 1'b1; ins3 = 12'hE00 + 12'(i);
            @(posedge clk); #1;
            n_tests++;
            if (instr3 !== 12'hE00 + 12'(i)) begin n_fail++; $display("FAIL wrap_head[%0d] got %h exp %h", i, instr3, 12'hE00 + 12'(i)); end
        end
        ld3 = 1'b0; next3 = 1'b0;
        n_tests++; if (count3 !== 2'd1) begin n_fail++; $display("FAIL wrap_count got %0d exp 1", count3); end
    endtask

    initial begin
        test_reset;
        test_fill_order;
        test_overflow;
        test_flush;
        test_empty_push_pop;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
